// File: rtl/jtbubl_shram_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtbubl_shram_arb_pkg                                             |
// | State encoding and requester indices shared by the shared-RAM    |
// | arbiter and its per-CPU port logic.                              |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package jtbubl_shram_arb_pkg;

  // Raw 3-bit state codes
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC_A = 3'd1;
  localparam logic [2:0] S_ACC_B = 3'd2;
  localparam logic [2:0] S_CAP_A = 3'd3;
  localparam logic [2:0] S_CAP_B = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ACC_A = S_ACC_A,
    ACC_B = S_ACC_B,
    CAP_A = S_CAP_A,
    CAP_B = S_CAP_B
  } state_t;

  // Requester indices, used for the round-robin pointer
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/jtbubl_shram_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtbubl_shram_port                                                |
// | Per-CPU side of the shared-RAM arbiter: tracks whether the       |
// | current bus cycle has been served, stalls the CPU until it has,  |
// | and holds the read data for it.                                  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module jtbubl_shram_port #(
  parameter int DW = 8
) (
  input  logic          clk24,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          cap,       // FSM is in this CPU's capture state
  input  logic          rd,        // the access being captured is a read
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] dout,
  output logic          pend,
  output logic          wait_n
);

  logic done;

  // A served cycle stays served until cs goes low, so each cs assertion
  // produces exactly one RAM access.
  assign pend   = cs & ~done;
  assign wait_n = ~pend;

  // Track completion and latch read data at the end of the access
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      dout <= '0;
    end else begin
      if (!cs)
        done <= 1'b0;
      else if (cap)
        done <= 1'b1;
      // Data is captured even if cs dropped mid-access
      if (cap && rd)
        dout <= ram_dout;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtbubl_shram_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jtbubl_shram_arb                                                 |
// | Lets the main (A) and sub (B) Z80s share one single-port work    |
// | RAM. Accesses are serialised by a small FSM with a round-robin   |
// | pointer used to break ties.                                      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module jtbubl_shram_arb
  import jtbubl_shram_arb_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk24,
  input  logic          rst_n,
  // main CPU
  input  logic          a_cs,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_wait_n,
  // sub CPU
  input  logic          b_cs,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_wait_n,
  // RAM
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  state_t state;
  logic   last;     // requester granted on the most recent tie
  logic   acc_we;   // direction of the access in flight
  logic   pend_a;
  logic   pend_b;
  logic   grant_a;

  // A wins when alone, or on a tie when B had the previous tie
  assign grant_a = pend_a & (~pend_b | (last == REQ_B));

  jtbubl_shram_port #(.DW(DW)) u_port_a (
    .clk24    ( clk24            ),
    .rst_n    ( rst_n            ),
    .cs       ( a_cs             ),
    .cap      ( state == CAP_A   ),
    .rd       ( ~acc_we          ),
    .ram_dout ( ram_dout         ),
    .dout     ( a_dout           ),
    .pend     ( pend_a           ),
    .wait_n   ( a_wait_n         )
  );

  jtbubl_shram_port #(.DW(DW)) u_port_b (
    .clk24    ( clk24            ),
    .rst_n    ( rst_n            ),
    .cs       ( b_cs             ),
    .cap      ( state == CAP_B   ),
    .rd       ( ~acc_we          ),
    .ram_dout ( ram_dout         ),
    .dout     ( b_dout           ),
    .pend     ( pend_b           ),
    .wait_n   ( b_wait_n         )
  );

  // Arbitration FSM with registered RAM-side outputs
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= REQ_B;
      acc_we   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_a) begin
            state    <= ACC_A;
            ram_addr <= a_addr;
            ram_din  <= a_din;
            ram_we   <= a_we;
            acc_we   <= a_we;
            if (pend_b) last <= REQ_A;
          end else if (pend_b) begin
            state    <= ACC_B;
            ram_addr <= b_addr;
            ram_din  <= b_din;
            ram_we   <= b_we;
            acc_we   <= b_we;
            if (pend_a) last <= REQ_B;
          end
        end
        // Write strobe lasts the single ACC cycle
        ACC_A: begin
          ram_we <= 1'b0;
          state  <= CAP_A;
        end
        ACC_B: begin
          ram_we <= 1'b0;
          state  <= CAP_B;
        end
        CAP_A, CAP_B: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_shram_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_jtbubl_shram_arb                                              |
// | Self-checking bench for the shared-RAM arbiter, with a behavioural|
// | one-cycle-latency RAM and scoreboard queues for writes and reads.|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_jtbubl_shram_arb;
  import jtbubl_shram_arb_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk24 = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_cs = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_din = '0;
  logic [DW-1:0] a_dout;
  logic          a_wait_n;
  logic          b_cs = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din = '0;
  logic [DW-1:0] b_dout;
  logic          b_wait_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wq[$];     // expected RAM writes, in order
  logic [DW-1:0] rq_a[$];   // expected read data for A
  logic [DW-1:0] rq_b[$];   // expected read data for B
  wr_t           exp_w;
  int            acc_a = 0, acc_b = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk24 = ~clk24;

  jtbubl_shram_arb #(.AW(AW), .DW(DW)) dut (
    .clk24    ( clk24    ),
    .rst_n    ( rst_n    ),
    .a_cs     ( a_cs     ),
    .a_we     ( a_we     ),
    .a_addr   ( a_addr   ),
    .a_din    ( a_din    ),
    .a_dout   ( a_dout   ),
    .a_wait_n ( a_wait_n ),
    .b_cs     ( b_cs     ),
    .b_we     ( b_we     ),
    .b_addr   ( b_addr   ),
    .b_din    ( b_din    ),
    .b_dout   ( b_dout   ),
    .b_wait_n ( b_wait_n ),
    .ram_addr ( ram_addr ),
    .ram_din  ( ram_din  ),
    .ram_we   ( ram_we   ),
    .ram_dout ( ram_dout )
  );

  // Single-port RAM, one clock read latency
  always @(posedge clk24) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Write scoreboard and access counters
  always @(negedge clk24) begin
    if (rst_n) begin
      if (dut.state == ACC_A) acc_a++;
      if (dut.state == ACC_B) acc_b++;
      if (ram_we) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL ram_write_unexpected got addr=%h data=%h, required no write", ram_addr, ram_din);
        end else begin
          exp_w = wq.pop_front();
          if ({ram_addr, ram_din} !== exp_w) begin
            failures++;
            $display("FAIL ram_write got addr=%h data=%h, required addr=%h data=%h",
                     ram_addr, ram_din, exp_w.addr, exp_w.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // One CPU bus cycle: raise cs, count stall clocks, check read data,
  // optionally hold cs, then release it for one clock.
  task automatic cpu_access(input int port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] din, input int hold, output int waited);
    logic [DW-1:0] exp_d;
    if (port == 0) begin a_cs = 1'b1; a_we = we; a_addr = addr; a_din = din; end
    else           begin b_cs = 1'b1; b_we = we; b_addr = addr; b_din = din; end
    waited = 0;
    do begin
      @(posedge clk24); #1;
      waited++;
    end while (!(port == 0 ? a_wait_n : b_wait_n) && waited < 20);
    checks++;
    if (!(port == 0 ? a_wait_n : b_wait_n)) begin
      failures++;
      $display("FAIL wait_timeout port=%0d got wait_n=0 after %0d clocks, required 1", port, waited);
    end
    if (!we) begin
      exp_d = (port == 0) ? rq_a.pop_front() : rq_b.pop_front();
      checks++;
      if ((port == 0 ? a_dout : b_dout) !== exp_d) begin
        failures++;
        $display("FAIL read_data port=%0d got %h, required %h", port,
                 (port == 0 ? a_dout : b_dout), exp_d);
      end
    end
    repeat (hold) begin @(posedge clk24); #1; end
    if (port == 0) a_cs = 1'b0; else b_cs = 1'b0;
    @(posedge clk24); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk24);
    #1 rst_n = 1'b1;
    @(posedge clk24); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk24);
    #1;
    checks++;
    if ({a_wait_n, b_wait_n, ram_we} !== 3'b110) begin
      failures++;
      $display("FAIL reset_ctrl got a_wait_n,b_wait_n,ram_we=%b, required 110", {a_wait_n, b_wait_n, ram_we});
    end
    checks++;
    if ({ram_addr, ram_din, a_dout, b_dout} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%h din=%h a_dout=%h b_dout=%h, required all 0",
               ram_addr, ram_din, a_dout, b_dout);
    end
    checks++;
    if (dut.state !== IDLE || dut.last !== REQ_B) begin
      failures++;
      $display("FAIL reset_fsm got state=%0d last=%b, required state=0 last=1", dut.state, dut.last);
    end
    rst_n = 1'b1;
    @(posedge clk24); #1;
  endtask

  task automatic test_single_read_a();
    int w, a0;
    mem[13'h0123] = 8'h5A;
    a0 = acc_a;
    rq_a.push_back(8'h5A);
    cpu_access(0, 1'b0, 13'h0123, 8'h00, 0, w);
    checks++;
    if (w != 3) begin failures++; $display("FAIL read_a_wait got %0d clocks, required 3", w); end
    checks++;
    if (acc_a - a0 != 1) begin failures++; $display("FAIL read_a_accesses got %0d, required 1", acc_a - a0); end
  endtask

  task automatic test_single_write_b();
    int w, b0;
    b0 = acc_b;
    wq.push_back({13'h1FFF, 8'hC3});
    cpu_access(1, 1'b1, 13'h1FFF, 8'hC3, 10, w);
    checks++;
    if (w != 3) begin failures++; $display("FAIL write_b_wait got %0d clocks, required 3", w); end
    checks++;
    if (acc_b - b0 != 1) begin failures++; $display("FAIL write_b_accesses got %0d, required 1", acc_b - b0); end
    checks++;
    if (mem[13'h1FFF] !== 8'hC3) begin failures++; $display("FAIL write_b_mem got %h, required c3", mem[13'h1FFF]); end
  endtask

  task automatic test_simultaneous();
    int wa, wb;
    pulse_reset();
    mem[13'h0010] = 8'h11;
    mem[13'h0020] = 8'h22;
    rq_a.push_back(8'h11);
    rq_b.push_back(8'h22);
    fork
      cpu_access(0, 1'b0, 13'h0010, 8'h00, 0, wa);
      cpu_access(1, 1'b0, 13'h0020, 8'h00, 0, wb);
    join
    checks++;
    if (wa != 3 || wb != 6) begin
      failures++;
      $display("FAIL tie_first got wait a=%0d b=%0d, required a=3 b=6", wa, wb);
    end
    mem[13'h0011] = 8'h33;
    mem[13'h0021] = 8'h44;
    rq_a.push_back(8'h33);
    rq_b.push_back(8'h44);
    fork
      cpu_access(0, 1'b0, 13'h0011, 8'h00, 0, wa);
      cpu_access(1, 1'b0, 13'h0021, 8'h00, 0, wb);
    join
    checks++;
    if (wa != 6 || wb != 3) begin
      failures++;
      $display("FAIL tie_second got wait a=%0d b=%0d, required a=6 b=3", wa, wb);
    end
  endtask

  task automatic test_back_to_back();
    int a0, b0;
    a0 = acc_a;
    b0 = acc_b;
    // Tie last went to B, so A leads and grants then alternate
    for (int i = 0; i < 50; i++) begin
      wq.push_back({AW'(13'h0400 + i), DW'(i)});
      wq.push_back({AW'(13'h0800 + i), DW'(8'h80 + i)});
    end
    fork
      begin
        int w;
        for (int i = 0; i < 50; i++) begin
          cpu_access(0, 1'b1, AW'(13'h0400 + i), DW'(i), 0, w);
          checks++;
          if (w > 6) begin failures++; $display("FAIL contend_wait_a got %0d clocks, required <=6", w); end
        end
      end
      begin
        int w;
        for (int j = 0; j < 50; j++) begin
          cpu_access(1, 1'b1, AW'(13'h0800 + j), DW'(8'h80 + j), 0, w);
          checks++;
          if (w > 6) begin failures++; $display("FAIL contend_wait_b got %0d clocks, required <=6", w); end
        end
      end
    join
    checks++;
    if (acc_a - a0 != 50 || acc_b - b0 != 50 || wq.size() != 0) begin
      failures++;
      $display("FAIL contend_count got a=%0d b=%0d left=%0d, required 50 50 0",
               acc_a - a0, acc_b - b0, wq.size());
    end
  endtask

  task automatic test_drop_b();
    int w;
    wq.push_back({13'h0042, 8'h77});
    b_cs = 1'b1; b_we = 1'b1; b_addr = 13'h0042; b_din = 8'h77;
    @(posedge clk24); #1;
    checks++;
    if (dut.state !== ACC_B) begin failures++; $display("FAIL drop_b_state got %0d, required ACC_B", dut.state); end
    b_cs = 1'b0;
    b_addr = 13'h0000; b_din = 8'h00;
    repeat (4) begin @(posedge clk24); #1; end
    checks++;
    if (dut.u_port_b.done !== 1'b0 || b_wait_n !== 1'b1) begin
      failures++;
      $display("FAIL drop_b_done got done=%b wait_n=%b, required 0 1", dut.u_port_b.done, b_wait_n);
    end
    checks++;
    if (mem[13'h0042] !== 8'h77 || wq.size() != 0) begin
      failures++;
      $display("FAIL drop_b_write got mem=%h pending=%0d, required 77 0", mem[13'h0042], wq.size());
    end
    rq_b.push_back(8'h77);
    cpu_access(1, 1'b0, 13'h0042, 8'h00, 0, w);
    checks++;
    if (w != 3) begin failures++; $display("FAIL drop_b_fresh got %0d clocks, required 3", w); end
  endtask

  task automatic test_reset_mid_access();
    a_cs = 1'b1; a_we = 1'b0; a_addr = 13'h0123;
    repeat (2) begin @(posedge clk24); #1; end
    checks++;
    if (dut.state !== CAP_A) begin failures++; $display("FAIL mid_state got %0d, required CAP_A", dut.state); end
    rst_n = 1'b0;
    a_cs = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || a_dout !== 8'h00 || a_wait_n !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_out got ram_we=%b a_dout=%h a_wait_n=%b, required 0 00 1", ram_we, a_dout, a_wait_n);
    end
    checks++;
    if (dut.state !== IDLE || dut.last !== REQ_B) begin
      failures++;
      $display("FAIL mid_reset_fsm got state=%0d last=%b, required 0 1", dut.state, dut.last);
    end
    @(posedge clk24); #1 rst_n = 1'b1;
    @(posedge clk24); #1;
    // Reset during a write strobe must drop ram_we without a clock edge
    mem[13'h0050] = 8'h00;
    b_cs = 1'b1; b_we = 1'b1; b_addr = 13'h0050; b_din = 8'h99;
    @(posedge clk24); #1;
    checks++;
    if (ram_we !== 1'b1) begin failures++; $display("FAIL acc_we got %b, required 1", ram_we); end
    rst_n = 1'b0;
    b_cs = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin failures++; $display("FAIL async_we_drop got %b, required 0", ram_we); end
    repeat (2) @(posedge clk24);
    #1 rst_n = 1'b1;
    @(posedge clk24); #1;
    checks++;
    if (mem[13'h0050] !== 8'h00) begin failures++; $display("FAIL aborted_write got %h, required 00", mem[13'h0050]); end
  endtask

  initial begin
    test_reset();
    test_single_read_a();
    test_single_write_b();
    test_simultaneous();
    test_back_to_back();
    test_drop_b();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtbubl_shram_arb.md
# jtbubl_shram_arb

Arbiter that lets the main and sub Z80s share one single-port 8 kB work RAM, replacing a dual-port instance. It serialises accesses, issues per-CPU `wait_n`, and holds read data for each CPU until its cycle completes. It sits between the two CPU address decoders and a `jtframe_ram` instance.

## Interface
Parameters:
- `AW`, 13, RAM address width.
- `DW`, 8, data width.

Ports (all synchronous to `clk24` except reset):
- `clk24`  in  1  system clock, 24 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a_cs`  in  1  main CPU shared-RAM select; held high for the whole bus cycle.
- `a_we`  in  1  main CPU write strobe; qualified by `a_cs`.
- `a_addr`  in  AW  main CPU address.
- `a_din`  in  DW  main CPU write data.
- `a_dout`  out  DW  read data latched for main CPU.
- `a_wait_n`  out  1  low stalls the main CPU.
- `b_cs`, `b_we`, `b_addr`, `b_din`, `b_dout`, `b_wait_n`: same as the `a_*` ports, for the sub CPU.
- `ram_addr`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_dout`  in  DW  RAM read data; one clock read latency.

## Operation
- Per requester, `pend_x = x_cs & ~done_x`.
- `x_wait_n = ~pend_x`. This is combinational, so the CPU is stalled in the same cycle `cs` rises.
- FSM states: IDLE, ACC_A, ACC_B, CAP_A, CAP_B.
- IDLE:
  - If only one requester is pending, go to ACC of that requester.
  - If both are pending, grant the one not equal to `last`, then set `last` to the grantee.
  - If neither is pending, stay in IDLE.
- ACC_x:
  - `ram_addr`, `ram_din` and `ram_we` (`= x_we`) are registered from requester x, sampled at the IDLE→ACC transition.
  - Next state is always CAP_x.
- CAP_x:
  - `ram_we` returns to 0.
  - `x_dout` ← `ram_dout`, for reads only; writes leave `x_dout` unchanged.
  - `done_x` ← 1 if `x_cs` is still high.
  - Next state is IDLE.
- `done_x` clears in the first cycle `x_cs` is low. One `cs` assertion therefore yields exactly one RAM access; a write is never repeated.
- If `x_cs` drops during ACC_x or CAP_x (e.g. the CPU is reset), the RAM access still completes and `x_dout` is still updated on reads, but `done_x` is not set.
- `x_addr`, `x_we` and `x_din` are sampled only at the IDLE→ACC transition. Later changes are ignored until the next access.

## Timing
- Reset values:
  - State IDLE; `last` = B, so A wins the first tie.
  - `done_a` = `done_b` = 0.
  - `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0.
  - `a_dout` = `b_dout` = 0.
  - `x_wait_n` is 1 because `cs` is low.
- Uncontended access, with `cs` rising at edge n:
  - ACC at n+1; `ram_we` high during n+1 to n+2 for writes.
  - CAP at n+2; data valid and `wait_n` high after edge n+3.
  - Total: 3 clocks of wait.
- Contended access: the loser waits a further 3 clocks, 6 at most.
- With both requesters continuously pending, grants alternate A, B, A, B; neither starves.
- A request rising while the FSM is in CAP_y is seen in the following IDLE cycle.
- `rst_n` asserted mid-access: all state returns to the reset values immediately, and `ram_we` drops asynchronously.
- The RAM is outside this block, so its contents are not affected by reset.

## Structure
- A shared package holds the state encoding (3-bit localparams) and the requester index constants `REQ_A`/`REQ_B`.
- The per-requester logic (`pend`, `done`, `dout` latch, `wait_n`) is instantiated twice as sub-module `jtbubl_shram_port`. The FSM and `last` pointer live in the top.

## Test plan
- Single A read: preload addr 0x0123 = 0x5A; assert `a_cs`, `a_we`=0 → `a_wait_n` low for 3 clocks, `a_dout` = 0x5A, exactly one access on the RAM port.
- Single B write: `b_cs`, `b_we`=1, addr 0x1FFF, data 0xC3 → `ram_we` high for exactly 1 clock with addr 0x1FFF and data 0xC3; holding `b_cs` 10 more clocks causes no second write.
- Simultaneous A and B from reset: A is served first (`a_wait_n` high after 3 clocks), B after 6; then both re-request together → B is served first.
- Continuous contention for 100 accesses → grants strictly alternate, and each wait is ≤ 6 clocks.
- `b_cs` dropped during ACC_B → write completes, `done_b` stays 0; the next `b_cs` starts a fresh 3-clock access.
- `rst_n` pulsed low during CAP_A → `ram_we`=0, `a_dout`=0, state IDLE, `last`=B on release.
